// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the shift unit, the result FIFO and its consumer.
// A word moves on a rising edge only when its valid and ready are both high.
interface alu_result_fifo_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_result;
  logic             in_zero;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ready;

  modport slave (
    input  in_valid, in_result, in_zero, out_ready,
    output in_ready, out_valid, out_result, out_zero
  );

  modport master (
    output in_valid, in_result, in_zero, out_ready,
    input  in_ready, out_valid, out_result, out_zero
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO for shift results plus zero flag, with
// saturating zero-result counter and sticky drop / flag-mismatch status.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              zero_count,
  output logic                     drop,
  output logic                     mismatch
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic             zero;
    logic [WIDTH-1:0] result;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     zero_count_q, zero_count_d;
  logic            drop_q, drop_d;
  logic            mismatch_q, mismatch_d;
  logic            in_ready, out_valid, push, pop;

  always_comb begin
    // Ready comes from registered occupancy only, so a full FIFO refuses
    // a push even in a cycle where the head is being popped.
    in_ready     = (count_q < FULL);
    out_valid    = (count_q != '0);
    push         = bus.in_valid && in_ready;
    pop          = out_valid && bus.out_ready;

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    zero_count_d = zero_count_q;
    drop_d       = drop_q | (bus.in_valid & ~in_ready);
    mismatch_d   = mismatch_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{zero: bus.in_zero, result: bus.in_result};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (bus.in_zero && (zero_count_q != 16'hFFFF))
        zero_count_d = zero_count_q + 16'd1;
      if (bus.in_zero != (bus.in_result == '0))
        mismatch_d = 1'b1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      zero_count_q <= '0;
      drop_q       <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      zero_count_q <= zero_count_d;
      drop_q       <= drop_d;
      mismatch_q   <= mismatch_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = mem_q[rd_ptr_q].result;
  assign bus.out_zero   = mem_q[rd_ptr_q].zero;
  assign count          = count_q;
  assign zero_count     = zero_count_q;
  assign drop           = drop_q;
  assign mismatch       = mismatch_q;
endmodule
